// File: rtl/clk_divider_prog.sv
// clk_divider_prog: programmable integer clock divider.
// Produces either a near-50% divided clock or a one-cycle tick on div_out,
// plus a separate tick output, from a runtime-loadable divisor.
// Outputs are registered and meant for use as enables/data, not as clocks.
//
// Divisor handshake (valid/ready):
//   A transfer happens on a rising edge where div_valid & div_ready are both 1.
//   div_ready is 1 exactly when the single pending slot is empty. A divisor of
//   2 or more fills the slot (div_ready drops from the next cycle). A divisor
//   of 0 or 1 still completes the handshake but is discarded and answered by
//   a one-cycle cfg_err pulse. The producer may hold div_valid high; nothing
//   transfers while div_ready is 0.
//
// A pending divisor is only applied at a period boundary: the terminal-count
// edge while enabled, the next edge while disabled (count forced to 0), or a
// sync_clr edge. The slot frees on that same edge, so div_ready returns to 1
// in the following cycle.
module clk_divider_prog #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             mode,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_value,
  output logic             div_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_active
);

  localparam logic [WIDTH-1:0] RESET_DIV_W = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE_W       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO_W       = WIDTH'(2);

  // Pending divisor slot
  logic             pend_valid;
  logic [WIDTH-1:0] pend_div;

  // Next-state values
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] active_n;
  logic [WIDTH-1:0] pend_div_n;
  logic             pend_valid_n;
  logic             tick_n;
  logic             div_out_n;
  logic             cfg_err_n;

  // Decode helpers
  logic xfer;
  logic accept;
  logic terminal;
  logic apply;

  assign div_ready = ~pend_valid;

  // Next-state: counter, divisor application, pending slot and outputs
  always_comb begin
    xfer         = div_valid & div_ready;
    accept       = xfer & (div_value >= TWO_W);
    terminal     = (count == (div_active - ONE_W));
    count_n      = count;
    active_n     = div_active;
    pend_valid_n = pend_valid;
    pend_div_n   = pend_div;
    tick_n       = 1'b0;
    apply        = 1'b0;

    if (sync_clr) begin
      count_n = '0;
      apply   = pend_valid;
    end else if (en) begin
      if (terminal) begin
        count_n = '0;
        tick_n  = 1'b1;
        apply   = pend_valid;
      end else begin
        count_n = count + ONE_W;
      end
    end else if (pend_valid) begin
      // Idle divider: no period to finish, so restart cleanly on the new value
      count_n = '0;
      apply   = 1'b1;
    end

    if (apply) begin
      active_n     = pend_div;
      pend_valid_n = 1'b0;
    end

    // The slot is empty whenever a transfer is possible, so this never
    // collides with an apply on the same edge.
    if (accept) begin
      pend_valid_n = 1'b1;
      pend_div_n   = div_value;
    end

    cfg_err_n = xfer & ~accept;

    // Mode 0 is derived from the next count so div_out lines up with count;
    // high for the upper ceil(D/2) counts of the period.
    div_out_n = mode ? tick_n : (count_n >= (active_n >> 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      div_active <= RESET_DIV_W;
      pend_valid <= 1'b0;
      pend_div   <= '0;
      tick       <= 1'b0;
      div_out    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      count      <= count_n;
      div_active <= active_n;
      pend_valid <= pend_valid_n;
      pend_div   <= pend_div_n;
      tick       <= tick_n;
      div_out    <= div_out_n;
      cfg_err    <= cfg_err_n;
    end
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// tb_clk_divider_prog: directed and randomized checks of clk_divider_prog
// against a period-level reference model kept in the bench.
module tb_clk_divider_prog;

  localparam int W     = 8;
  localparam int RDIV  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         en, sync_clr, mode, div_valid;
  logic [W-1:0] div_value;
  logic         div_ready, cfg_err, div_out, tick;
  logic [W-1:0] count, div_active;

  clk_divider_prog #(.WIDTH(W), .RESET_DIV(RDIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sync_clr  (sync_clr),
    .mode      (mode),
    .div_valid (div_valid),
    .div_value (div_value),
    .div_ready (div_ready),
    .cfg_err   (cfg_err),
    .div_out   (div_out),
    .tick      (tick),
    .count     (count),
    .div_active(div_active)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks position within the current period, the divisor in force and the
  // queue of at most one accepted divisor waiting for a period boundary.
  int           m_pos;
  int           m_div;
  logic [W-1:0] pend_q[$];
  bit           m_tick, m_out, m_err;
  bit           m_took, m_wrap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_div = RDIV; pend_q.delete();
      m_tick = 0; m_out = 0; m_err = 0;
    end else begin
      m_took = div_valid && (pend_q.size() == 0);
      m_wrap = 0;
      if (sync_clr) begin
        m_pos = 0;
        if (pend_q.size() > 0) m_div = int'(pend_q.pop_front());
      end else if (en) begin
        if (m_pos + 1 == m_div) begin
          m_wrap = 1;
          m_pos  = 0;
          if (pend_q.size() > 0) m_div = int'(pend_q.pop_front());
        end else begin
          m_pos = m_pos + 1;
        end
      end else if (pend_q.size() > 0) begin
        m_div = int'(pend_q.pop_front());
        m_pos = 0;
      end
      m_err = m_took && (div_value < 2);
      if (m_took && div_value >= 2) pend_q.push_back(div_value);
      m_tick = m_wrap;
      // low for the first floor(D/2) positions of a period, high for the rest
      m_out = mode ? m_wrap : (m_pos >= m_div / 2);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("count",      int'(count),      m_pos);
      check("div_active", int'(div_active), m_div);
      check("div_ready",  int'(div_ready),  int'(pend_q.size() == 0));
      check("cfg_err",    int'(cfg_err),    int'(m_err));
      check("div_out",    int'(div_out),    int'(m_out));
      check("tick",       int'(tick),       int'(m_tick));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer a divisor while idle; it is captured on the next edge and
  // applied on the edge after.
  task automatic load_idle(input int d);
    en = 0; div_valid = 1; div_value = W'(d);
    cyc(1);
    div_valid = 0;
    cyc(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0; en = 0; sync_clr = 0; mode = 0; div_valid = 0; div_value = '0;
    cyc(3);
    rst_n = 1;
    check("rst_count",  int'(count), 0);
    check("rst_active", int'(div_active), 2);
    check("rst_ready",  int'(div_ready), 1);
    check("rst_out",    int'(div_out), 0);
    check("rst_tick",   int'(tick), 0);
    check("rst_err",    int'(cfg_err), 0);

    // Default divide-by-2: div_out toggles, tick every other cycle
    en = 1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      check("d2_out",  int'(div_out), int'(i % 2 == 0));
      check("d2_tick", int'(tick),    int'(i % 2 == 1));
    end

    // Odd divisor loaded while idle
    en = 0; div_valid = 1; div_value = 8'd5;
    cyc(1);
    check("d5_ready_busy", int'(div_ready), 0);
    div_valid = 0;
    cyc(1);
    check("d5_active", int'(div_active), 5);
    check("d5_count",  int'(count), 0);
    check("d5_ready",  int'(div_ready), 1);
    en = 1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("d5_out",  int'(div_out), int'(((i + 1) % 5) >= 2));
      check("d5_tick", int'(tick),    int'(i % 5 == 4));
    end
    mode = 1;
    cyc(12);
    mode = 0;

    // Boundary application: D=4 running, offer 7 while count=1
    load_idle(4);
    en = 1;
    cyc(1);
    check("b_count1", int'(count), 1);
    div_valid = 1; div_value = 8'd7;
    cyc(1);
    check("b_ready_busy", int'(div_ready), 0);
    check("b_active_old", int'(div_active), 4);
    div_valid = 0;
    cyc(1);
    check("b_active_hold", int'(div_active), 4);
    cyc(1);
    check("b_active_new", int'(div_active), 7);
    check("b_count_wrap", int'(count), 0);
    check("b_ready_free", int'(div_ready), 1);
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      check("b_period7_tick", int'(tick), int'(i == 6));
    end

    // Rejected divisor, then hold
    div_valid = 1; div_value = 8'd1;
    cyc(1);
    check("err_pulse",  int'(cfg_err), 1);
    check("err_active", int'(div_active), 7);
    check("err_ready",  int'(div_ready), 1);
    div_valid = 0;
    cyc(1);
    check("err_clear", int'(cfg_err), 0);
    en = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("hold_count", int'(count), 2);
      check("hold_out",   int'(div_out), 0);
      check("hold_tick",  int'(tick), 0);
    end

    // Synchronous clear at count=3 of D=6
    load_idle(6);
    en = 1;
    cyc(3);
    check("clr_pre_count", int'(count), 3);
    check("clr_pre_out",   int'(div_out), 1);
    sync_clr = 1;
    cyc(1);
    sync_clr = 0;
    check("clr_count", int'(count), 0);
    check("clr_out",   int'(div_out), 0);
    check("clr_tick",  int'(tick), 0);

    // Reset mid-period with a divisor pending
    cyc(2);
    div_valid = 1; div_value = 8'd9;
    cyc(1);
    div_valid = 0;
    check("rp_ready_busy", int'(div_ready), 0);
    #3 rst_n = 0;
    #1;
    check("rp_count",  int'(count), 0);
    check("rp_active", int'(div_active), RDIV);
    check("rp_ready",  int'(div_ready), 1);
    check("rp_out",    int'(div_out), 0);
    check("rp_tick",   int'(tick), 0);
    cyc(1);
    rst_n = 1;
    cyc(3);
    check("rp_active_after", int'(div_active), RDIV);

    // Randomized traffic checked by the model
    for (int i = 0; i < 4000; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      sync_clr  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      div_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 9))
        0:       div_value = W'($urandom_range(0, 1));
        1:       div_value = W'($urandom_range(2, 255));
        default: div_value = W'($urandom_range(2, 12));
      endcase
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 0;
        #2 rst_n = 1;
      end
      cyc(1);
    end

    en = 0; sync_clr = 0; div_valid = 0;
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
